// File: rtl/bkf_pkg.sv
// Shared definitions for the multi-channel breakpoint forwarder.
// Holds the register map, CTRL/ISR bit positions, the drain FSM
// state encoding, the command FIFO entry layout and a byte-strobe
// merge helper for the read-write registers.
package bkf_pkg;

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_STAT   = 12'h004;
  localparam logic [11:0] ADDR_CHAN   = 12'h008;
  localparam logic [11:0] ADDR_ISR    = 12'h00C;
  localparam logic [11:0] ADDR_INDEX  = 12'h010;
  localparam logic [11:0] ADDR_VALUE  = 12'h014;
  localparam logic [3:0]  STATUS_BASE = 4'h1;    // 0x100..0x1FF window

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int ISR_OVF    = 0;
  localparam int ISR_STCHG  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_WAIT_ACK
  } drain_st_e;

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] index;
    logic [31:0] value;
  } bkf_entry_t;

  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/bkf_cmd_fifo.sv
// Synchronous command FIFO with flush.
// Ports: clk/rst (async high), flush_i empties on the next edge and
// discards a same-cycle push; push_i/din_i write (accepted when not full,
// or full with a same-cycle pop); pop_i/dout_o read the head (dout_o is
// the current head, valid when !empty_o); level_o/full_o/empty_o status.
module bkf_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 68,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty; wraps naturally.
  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pop is logically first, so a push into a full FIFO with a pop succeeds.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bkf_forwarder_mc.sv
// Multi-channel breakpoint forwarder.
// An AXI4-Lite slave stages (channel, index, value) commands into a FIFO;
// a drain FSM presents each entry on bkf_valid[ch]/bkf_index/bkf_value,
// either as a one-cycle pulse (HS_MODE=0) or held until bkf_ack[ch]
// (HS_MODE=1). Per-channel status words are readable at 0x100+4c and a
// rising edge of bit READY_BIT on any channel raises ISR.stat_chg.
// interrupt is the registered irq_en & |ISR.
module bkf_forwarder_mc
  import bkf_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int HS_MODE    = 1,
  parameter int READY_BIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NUM_CH-1:0]     bkf_valid,
  input  logic [NUM_CH-1:0]     bkf_ack,
  output logic [31:0]           bkf_index,
  output logic [31:0]           bkf_value,
  input  logic [32*NUM_CH-1:0]  bk_status_i,
  output logic                  interrupt,
  input  logic                  s_axi_control_awvalid,
  output logic                  s_axi_control_awready,
  input  logic [11:0]           s_axi_control_awaddr,
  input  logic                  s_axi_control_wvalid,
  output logic                  s_axi_control_wready,
  input  logic [31:0]           s_axi_control_wdata,
  input  logic [3:0]            s_axi_control_wstrb,
  output logic                  s_axi_control_bvalid,
  input  logic                  s_axi_control_bready,
  output logic [1:0]            s_axi_control_bresp,
  input  logic                  s_axi_control_arvalid,
  output logic                  s_axi_control_arready,
  input  logic [11:0]           s_axi_control_araddr,
  output logic                  s_axi_control_rvalid,
  input  logic                  s_axi_control_rready,
  output logic [31:0]           s_axi_control_rdata,
  output logic [1:0]            s_axi_control_rresp
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- AXI write path ----------------
  logic awready_q, bvalid_q, wr_hs;
  logic [11:0] wa;
  logic [31:0] wd;
  logic [3:0]  ws;

  assign wa    = s_axi_control_awaddr;
  assign wd    = s_axi_control_wdata;
  assign ws    = s_axi_control_wstrb;
  assign wr_hs = awready_q & s_axi_control_awvalid & s_axi_control_wvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      // one-cycle ready pulse; cannot re-arm while a response is pending
      awready_q <= ~awready_q & s_axi_control_awvalid & s_axi_control_wvalid & ~bvalid_q;
      if (wr_hs)                     bvalid_q <= 1'b1;
      else if (s_axi_control_bready) bvalid_q <= 1'b0;
    end
  end

  assign s_axi_control_awready = awready_q;
  assign s_axi_control_wready  = awready_q;
  assign s_axi_control_bvalid  = bvalid_q;
  assign s_axi_control_bresp   = 2'b00;

  // ---------------- registers ----------------
  logic        en_q, irq_en_q, ovf_q, irq_q;
  logic [3:0]  chan_q;
  logic [31:0] index_q;
  logic [1:0]  isr_q, isr_set, isr_clr;
  logic [NUM_CH-1:0][31:0] stat_q, stat_in;
  logic [NUM_CH-1:0]       rise;

  logic wr_ctrl, wr_isr, wr_value, flush, chan_ok, push, full_drop;
  logic fifo_full, fifo_empty, pop;
  logic [AW:0] fifo_level;
  bkf_entry_t  head;

  assign wr_ctrl  = wr_hs & (wa == ADDR_CTRL);
  assign wr_isr   = wr_hs & (wa == ADDR_ISR);
  assign wr_value = wr_hs & (wa == ADDR_VALUE);
  assign flush    = wr_ctrl & ws[0] & wd[CTRL_FLUSH];
  assign chan_ok  = ({1'b0, chan_q} < 5'(NUM_CH));
  assign push     = wr_value & chan_ok;
  assign full_drop = push & fifo_full & ~pop;

  assign stat_in = bk_status_i;
  always_comb begin
    rise = '0;
    for (int c = 0; c < NUM_CH; c++)
      rise[c] = stat_in[c][READY_BIT] & ~stat_q[c][READY_BIT];
  end

  assign isr_set[ISR_OVF]   = (wr_value & ~chan_ok) | full_drop;
  assign isr_set[ISR_STCHG] = |rise;
  assign isr_clr            = (wr_isr & ws[0]) ? wd[1:0] : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      chan_q   <= '0;
      index_q  <= '0;
      isr_q    <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      stat_q   <= '0;
    end else begin
      if (wr_ctrl & ws[0]) begin
        en_q     <= wd[CTRL_EN];
        irq_en_q <= wd[CTRL_IRQEN];
      end
      if (wr_hs & (wa == ADDR_CHAN) & ws[0]) chan_q <= wd[3:0];
      if (wr_hs & (wa == ADDR_INDEX))        index_q <= wmerge(index_q, wd, ws);
      if (full_drop) ovf_q <= 1'b1;
      isr_q  <= (isr_q & ~isr_clr) | isr_set;   // set beats W1C
      irq_q  <= irq_en_q & (|isr_q);
      stat_q <= stat_in;
    end
  end

  assign interrupt = irq_q;

  // ---------------- command FIFO ----------------
  bkf_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(bkf_entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .din_i   ({chan_q, index_q, wd}),
    .pop_i   (pop),
    .dout_o  (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- drain FSM ----------------
  drain_st_e         st_q, st_d;
  logic [NUM_CH-1:0] vld_q, vld_d;
  logic [31:0]       bidx_q, bidx_d, bval_q, bval_d;
  logic              ack_hit;

  // vld_q is one-hot on the presented channel, so this selects its ack only.
  assign ack_hit = |(bkf_ack & vld_q);

  always_comb begin
    st_d   = st_q;
    vld_d  = vld_q;
    bidx_d = bidx_q;
    bval_d = bval_q;
    pop    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (en_q & ~fifo_empty) begin
          pop    = 1'b1;
          vld_d  = NUM_CH'(1) << head.ch;
          bidx_d = head.index;
          bval_d = head.value;
          st_d   = ST_PRESENT;
        end
      end
      ST_PRESENT, ST_WAIT_ACK: begin
        if (HS_MODE == 0 || ack_hit) begin
          vld_d = '0;
          st_d  = ST_IDLE;
        end else begin
          st_d  = ST_WAIT_ACK;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      vld_q  <= '0;
      bidx_q <= '0;
      bval_q <= '0;
    end else begin
      st_q   <= st_d;
      vld_q  <= vld_d;
      bidx_q <= bidx_d;
      bval_q <= bval_d;
    end
  end

  assign bkf_valid = vld_q;
  assign bkf_index = bidx_q;
  assign bkf_value = bval_q;

  // ---------------- AXI read path ----------------
  logic        arready_q, rvalid_q, rvalid_d, ar_hs;
  logic [31:0] rdata_q, rd_mux;
  logic [11:0] ra;

  assign ra       = s_axi_control_araddr;
  assign ar_hs    = s_axi_control_arvalid & arready_q;
  assign rvalid_d = ar_hs | (rvalid_q & ~s_axi_control_rready);

  always_comb begin
    rd_mux = '0;
    case (ra)
      ADDR_CTRL:  rd_mux = {29'b0, irq_en_q, 1'b0, en_q};
      ADDR_STAT:  rd_mux = {21'b0, ovf_q, fifo_empty, fifo_full, 8'(fifo_level)};
      ADDR_CHAN:  rd_mux = {28'b0, chan_q};
      ADDR_ISR:   rd_mux = {30'b0, isr_q};
      ADDR_INDEX: rd_mux = index_q;
      default: begin
        if (ra[11:8] == STATUS_BASE && ra[1:0] == 2'b00)
          for (int c = 0; c < NUM_CH; c++)
            if (ra[7:2] == 6'(c)) rd_mux = stat_q[c];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= ~rvalid_d;     // tracks !rvalid, but held low in reset
      if (ar_hs) rdata_q <= rd_mux;
    end
  end

  assign s_axi_control_arready = arready_q;
  assign s_axi_control_rvalid  = rvalid_q;
  assign s_axi_control_rdata   = rdata_q;
  assign s_axi_control_rresp   = 2'b00;

endmodule
